pnr_histogram: RTL and testbench

- Downstream consumer of the photon-number-resolving stage.
- Takes the per-trigger photon number (0..8) produced after each delayed trigger and accumulates a histogram over a programmed number of shots.
- Publishes a frozen snapshot that the register bus can read while the next acquisition runs.
- Sits in the ADC_CLK domain, between the PNR discriminator and the system register interface.

---
 rtl/pnr_pkg.sv | 16 +
 rtl/pnr_histogram.sv | 130 +++++++++++++
 tb/tb_pnr_histogram.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pnr_pkg.sv
// Shared typing for the photon-number-resolving path: bin geometry,
// photon-number / bin-count types and the histogram FSM states.
package pnr_pkg;
  localparam int NUM_BINS = 9;
  localparam int PN_W     = 4;
  localparam int CNT_W    = 32;

  typedef logic [PN_W-1:0]  pn_t;
  typedef logic [CNT_W-1:0] bin_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SNAP
  } hist_state_t;
endpackage

// File: rtl/pnr_histogram.sv
// Photon-number histogram: accumulates per-trigger photon numbers into
// working bins over a programmed shot count, then copies them into a
// frozen snapshot that the register bus reads while the next run proceeds.
module pnr_histogram
  import pnr_pkg::*;
#(
  parameter int NUM_BINS = pnr_pkg::NUM_BINS,
  parameter int PN_W     = pnr_pkg::PN_W,
  parameter int CNT_W    = pnr_pkg::CNT_W,
  parameter int SHOTS_W  = 32
) (
  input  logic               ADC_CLK,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               continuous_i,
  input  logic [SHOTS_W-1:0] shots_target_i,
  input  logic               pn_valid_i,
  input  logic [PN_W-1:0]    pn_i,
  input  logic [PN_W-1:0]    rd_addr_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [SHOTS_W-1:0] shots_o,
  output logic               range_err_o,
  output logic               sat_o,
  output logic               missed_o
);

  logic [NUM_BINS-1:0][CNT_W-1:0] bins_q;
  logic [NUM_BINS-1:0][CNT_W-1:0] snap_q;
  logic [SHOTS_W-1:0]             target_q;
  hist_state_t                    state_q, state_d;
  logic                           rearm;
  logic                           accept;
  logic                           last_shot;
  logic                           in_range;
  logic [PN_W-1:0]                bin_idx;
  logic                           bin_full;

  // Out-of-range photon numbers are folded into the top bin.
  assign in_range  = (int'(pn_i) < NUM_BINS);
  assign bin_idx   = in_range ? pn_i : PN_W'(NUM_BINS - 1);
  assign bin_full  = (bins_q[bin_idx] == '1);
  // A start in the same cycle wins over counting.
  assign accept    = (state_q == ACCUM) && pn_valid_i && !start_i;
  assign last_shot = accept && ((shots_o + SHOTS_W'(1)) == target_q);
  assign busy_o    = (state_q != IDLE);

  // Next state; rearm covers both start_i and the continuous re-arm out of SNAP.
  always_comb begin
    state_d = state_q;
    rearm   = 1'b0;
    if (start_i) begin
      rearm   = 1'b1;
      state_d = (shots_target_i == '0) ? SNAP : ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (last_shot) state_d = SNAP;
        SNAP: begin
          if (continuous_i) begin
            rearm   = 1'b1;
            state_d = (shots_target_i == '0) ? SNAP : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Working bins, shot counter and latched target; bins saturate at all-ones.
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      bins_q   <= '0;
      shots_o  <= '0;
      target_q <= '0;
    end else if (rearm) begin
      bins_q   <= '0;
      shots_o  <= '0;
      target_q <= shots_target_i;
    end else if (accept) begin
      shots_o <= shots_o + SHOTS_W'(1);
      if (!bin_full) bins_q[bin_idx] <= bins_q[bin_idx] + CNT_W'(1);
    end
  end

  // Sticky status flags, cleared only by start_i.
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      range_err_o <= 1'b0;
      sat_o       <= 1'b0;
      missed_o    <= 1'b0;
    end else if (start_i) begin
      range_err_o <= 1'b0;
      sat_o       <= 1'b0;
      missed_o    <= 1'b0;
    end else begin
      if (accept && !in_range)              range_err_o <= 1'b1;
      if (accept && bin_full)               sat_o       <= 1'b1;
      if (pn_valid_i && state_q != ACCUM)   missed_o    <= 1'b1;
    end
  end

  // Snapshot copy on the SNAP cycle; done pulses next cycle unless aborted.
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      snap_q <= '0;
      done_o <= 1'b0;
    end else begin
      if (state_q == SNAP) snap_q <= bins_q;
      done_o <= (state_q == SNAP) && !start_i;
    end
  end

  // Registered snapshot read; reads during the copy see the old snapshot.
  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i)                           rd_data_o <= '0;
    else if (int'(rd_addr_i) < NUM_BINS) rd_data_o <= snap_q[rd_addr_i];
    else                                 rd_data_o <= '0;
  end

endmodule

// File: tb/tb_pnr_histogram.sv
// Directed bench for pnr_histogram. Stimulus pushes expected done cycles and
// expected read data into queues; a monitor pops and compares as the DUT
// presents done_o pulses and read data. A CNT_W=4 copy shares the inputs
// for the saturation case.
module tb_pnr_histogram;
  logic        ADC_CLK = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [31:0] shots_target_i = '0;
  logic        pn_valid_i = 1'b0;
  logic [3:0]  pn_i = '0;
  logic [3:0]  rd_addr_i = '0;

  logic [31:0] rd_data_o, shots_o;
  logic        busy_o, done_o, range_err_o, sat_o, missed_o;
  logic [3:0]  rd_data_s;
  logic [31:0] shots_s;
  logic        busy_s, done_s, range_s, sat_s, missed_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rd_req = 1'b0;
  logic rd_req_q = 1'b0;
  int done_q[$];
  logic [31:0] rd_q[$];

  pnr_histogram dut (
    .ADC_CLK(ADC_CLK), .rst_i(rst_i), .start_i(start_i), .continuous_i(continuous_i),
    .shots_target_i(shots_target_i), .pn_valid_i(pn_valid_i), .pn_i(pn_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .busy_o(busy_o), .done_o(done_o),
    .shots_o(shots_o), .range_err_o(range_err_o), .sat_o(sat_o), .missed_o(missed_o)
  );

  pnr_histogram #(.CNT_W(4)) dut_s (
    .ADC_CLK(ADC_CLK), .rst_i(rst_i), .start_i(start_i), .continuous_i(continuous_i),
    .shots_target_i(shots_target_i), .pn_valid_i(pn_valid_i), .pn_i(pn_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_s), .busy_o(busy_s), .done_o(done_s),
    .shots_o(shots_s), .range_err_o(range_s), .sat_o(sat_s), .missed_o(missed_s)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  always @(posedge ADC_CLK) begin
    cyc      <= cyc + 1;
    rd_req_q <= rd_req;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: done pulses and read data against the scoreboard queues.
  always @(negedge ADC_CLK) begin
    if (!rst_i && done_o) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        int e;
        e = done_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d expected %0d", cyc, e);
        end
      end
    end else if (done_q.size() != 0 && done_q[0] < cyc) begin
      int e;
      e = done_q.pop_front();
      checks++;
      errors++;
      $display("FAIL done_missing: got none by cycle %0d expected at %0d", cyc, e);
    end
    if (rd_req_q) begin
      logic [31:0] e;
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_scoreboard: got data %0d with no expected entry", rd_data_o);
      end else begin
        e = rd_q.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL rd_data: got %0d expected %0d (cycle %0d)", rd_data_o, e, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ADC_CLK);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input int tgt);
    start_i = 1'b1;
    shots_target_i = tgt;
    if (tgt == 0) done_q.push_back(cyc + 2);
    tick();
    start_i = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] pn);
    pn_valid_i = 1'b1;
    pn_i = pn;
    tick();
    pn_valid_i = 1'b0;
  endtask

  // Final shot: SNAP follows, done the cycle after.
  task automatic strobe_last(input logic [3:0] pn);
    done_q.push_back(cyc + 2);
    strobe(pn);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_addr_i = a;
    rd_req = 1'b1;
    rd_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    // Reset state
    gap(2);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_shots", shots_o, 0);
    chk("rst_flags", {range_err_o, sat_o, missed_o}, 0);
    rst_i = 1'b0;
    tick();

    // Basic run: target 5, pn 0,1,1,8,3
    start(5);
    chk("t1_busy_accum", busy_o, 1);
    chk("t1_shots0", shots_o, 0);
    strobe(0); gap(1);
    strobe(1); gap(1);
    strobe(1); gap(1);
    strobe(8); gap(1);
    strobe_last(3);
    chk("t1_shots_final", shots_o, 5);
    chk("t1_busy_snap", busy_o, 1);
    rd(1, 0);                       // coincides with the copy: old snapshot
    chk("t1_busy_done", busy_o, 0);
    chk("t1_shots_hold", shots_o, 5);
    rd(1, 2);
    rd(0, 1); rd(2, 0); rd(3, 1); rd(4, 0); rd(5, 0);
    rd(6, 0); rd(7, 0); rd(8, 1); rd(9, 0); rd(15, 0);
    chk("t1_flags", {range_err_o, sat_o, missed_o}, 0);

    // Zero target: straight to SNAP, empty snapshot
    start(0);
    chk("t2_busy_snap", busy_o, 1);
    tick();
    chk("t2_busy_done", busy_o, 0);
    chk("t2_shots", shots_o, 0);
    for (int i = 0; i < 9; i++) rd(4'(i), 0);

    // Out-of-range photon number lands in bin 8
    start(2);
    strobe(12);
    chk("t3_range_err", range_err_o, 1);
    chk("t3_shots1", shots_o, 1);
    strobe_last(8);
    gap(2);
    rd(8, 2); rd(0, 0);
    chk("t3_range_sticky", range_err_o, 1);

    // Continuous mode, target 3, strobe every cycle on pn=4
    continuous_i = 1'b1;
    done_q.push_back(cyc + 5);
    done_q.push_back(cyc + 9);
    done_q.push_back(cyc + 13);
    start(3);
    chk("t4_range_cleared", range_err_o, 0);
    chk("t4_missed0", missed_o, 0);
    pn_valid_i = 1'b1;
    pn_i = 4'd4;
    gap(11);                        // now in the third SNAP cycle
    pn_valid_i = 1'b0;
    continuous_i = 1'b0;
    chk("t4_missed", missed_o, 1);
    tick();
    chk("t4_busy_end", busy_o, 0);
    chk("t4_shots", shots_o, 3);
    rd(4, 3); rd(0, 0);

    // Abort after 2 of 4 shots; start-cycle strobe not counted
    start(4);
    strobe(5); strobe(5);
    chk("t5_shots2", shots_o, 2);
    start_i = 1'b1; shots_target_i = 4; pn_valid_i = 1'b1; pn_i = 4'd5;
    tick();
    start_i = 1'b0; pn_valid_i = 1'b0;
    chk("t5_shots_reset", shots_o, 0);
    chk("t5_missed_clr", missed_o, 0);
    strobe(6); strobe(6); strobe(7);
    strobe_last(0);
    gap(2);
    rd(5, 0); rd(6, 2); rd(7, 1); rd(0, 1);

    // Saturation on the CNT_W=4 copy: 20 hits on pn=2
    start(20);
    for (int i = 0; i < 19; i++) strobe(2);
    strobe_last(2);
    gap(2);
    rd(2, 20);
    chk("t6_small_bin2", rd_data_s, 15);
    chk("t6_small_sat", sat_s, 1);
    chk("t6_main_sat", sat_o, 0);

    // Reset mid-acquisition
    start(10);
    strobe(2); strobe(2); strobe(2);
    rst_i = 1'b1;
    #1;
    chk("t7_busy", busy_o, 0);
    chk("t7_shots", shots_o, 0);
    chk("t7_rd_data", rd_data_o, 0);
    chk("t7_flags", {done_o, range_err_o, sat_o, missed_o}, 0);
    chk("t7_small_sat", sat_s, 0);
    tick();
    rst_i = 1'b0;
    tick();
    rd(2, 0);
    gap(3);

    chk("done_queue_empty", done_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
